// File: rtl/iobuf_filtered.sv
// Tri-state pad buffer with a clocked receive path: synchronizer, glitch filter and edge pulses.
// Intended for open-drain buses (I tied 0, T as drive-low enable) where the pad needs debouncing.
module iobuf_filtered #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter logic INIT_VAL    = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  IO,
  input  logic I,
  input  logic T,
  output logic O,
  output logic O_SYNC,
  output logic O_FILT,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("iobuf_filtered: SYNC_STAGES must be in 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
      $error("iobuf_filtered: FILTER_LEN must be in 1..15");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   filt_q;
  logic                   rise_q;
  logic                   fall_q;

  // Drive path is purely combinational and ignores reset.
  assign IO = T ? 1'bz : I;
  assign O  = IO;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{INIT_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], O};
    end
  end

  assign O_SYNC = sync_q[SYNC_STAGES-1];

  // A new level is accepted on the edge where it has been seen FILTER_LEN times in a row;
  // the counter clears on that edge, so it never exceeds FILTER_LEN-1 and cannot wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_q <= INIT_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (O_SYNC == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= O_SYNC;
        cnt_q  <= '0;
        rise_q <= O_SYNC;
        fall_q <= ~O_SYNC;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign O_FILT = filt_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;

endmodule

// File: tb/tb_iobuf_filtered.sv
// Directed bench for iobuf_filtered: drive-path vector table plus multi-cycle receive-path sequences.
module tb_iobuf_filtered;

  logic clk;
  logic rst;
  logic t;
  logic i;
  logic ext_en;
  logic ext_val;
  logic ext2_val;

  wire  io_pad;
  wire  io_pad2;
  logic o, o_sync, o_filt, rise, fall;
  logic o2, o_sync2, o_filt2, rise2, fall2;

  int pass_cnt = 0;
  int total_cnt = 0;

  pullup (io_pad);
  assign io_pad  = ext_en ? ext_val : 1'bz;
  assign io_pad2 = ext2_val;

  iobuf_filtered dut (
    .CLK(clk), .RST(rst), .IO(io_pad), .I(i), .T(t),
    .O(o), .O_SYNC(o_sync), .O_FILT(o_filt), .RISE(rise), .FALL(fall)
  );

  iobuf_filtered #(.SYNC_STAGES(4), .FILTER_LEN(1), .INIT_VAL(1'b0)) dut2 (
    .CLK(clk), .RST(rst), .IO(io_pad2), .I(1'b0), .T(1'b1),
    .O(o2), .O_SYNC(o_sync2), .O_FILT(o_filt2), .RISE(rise2), .FALL(fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  t;
    logic  i;
    logic  ext_en;
    logic  ext_val;
    logic  rst;
    logic  exp_o;
  } drive_vec_t;

  drive_vec_t vecs [7];

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input drive_vec_t v);
    t       = v.t;
    i       = v.i;
    ext_en  = v.ext_en;
    ext_val = v.ext_val;
    rst     = v.rst;
    #2;
  endtask

  // After reset release with IO held low and O_FILT idle high: sync after 2 edges, filter after 5.
  task automatic checkFallAfterRelease(input string tag);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("%s sync k=%0d", tag, k), o_sync, (k >= 2) ? 1'b0 : 1'b1);
      checkOutput($sformatf("%s filt k=%0d", tag, k), o_filt, (k >= 5) ? 1'b0 : 1'b1);
      checkOutput($sformatf("%s fall k=%0d", tag, k), fall, (k == 5) ? 1'b1 : 1'b0);
      checkOutput($sformatf("%s rise k=%0d", tag, k), rise, 1'b0);
    end
  endtask

  // IO low for len cycles from idle high; only len >= 3 reaches O_FILT.
  task automatic pulseLow(input int len);
    logic filt_low;
    ext_val = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == len) ext_val = 1'b1;
      filt_low = (len >= 3) && (k >= 5) && (k <= len + 4);
      checkOutput($sformatf("glitch%0d sync k=%0d", len, k), o_sync,
                  (k >= 2 && k <= len + 1) ? 1'b0 : 1'b1);
      checkOutput($sformatf("glitch%0d filt k=%0d", len, k), o_filt, ~filt_low);
      checkOutput($sformatf("glitch%0d fall k=%0d", len, k), fall,
                  (len >= 3 && k == 5) ? 1'b1 : 1'b0);
      checkOutput($sformatf("glitch%0d rise k=%0d", len, k), rise,
                  (len >= 3 && k == len + 5) ? 1'b1 : 1'b0);
    end
  endtask

  logic hist [0:70];
  logic exp_filt;
  logic prev_filt;

  initial begin
    vecs[0] = '{"ext_high",       1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{"pullup_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"drive_low",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"release_high",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"loopback_high",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{"drive_no_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"ext_low",        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; t = 1'b1; i = 1'b0; ext_en = 1'b1; ext_val = 1'b1; ext2_val = 1'b0;
    #2;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v]);
      checkOutput({vecs[v].name, " O"}, o, vecs[v].exp_o);
      checkOutput({vecs[v].name, " pad"}, io_pad, vecs[v].exp_o);
    end

    // Reset held with IO low: outputs sit at INIT_VAL, no pulses.
    t = 1'b1; ext_en = 1'b1; ext_val = 1'b0; rst = 1'b1;
    tick();
    checkOutput("rst sync", o_sync, 1'b1);
    checkOutput("rst filt", o_filt, 1'b1);
    checkOutput("rst rise", rise, 1'b0);
    checkOutput("rst fall", fall, 1'b0);
    rst = 1'b0;
    checkFallAfterRelease("release");

    ext_val = 1'b1;
    repeat (10) tick();
    checkOutput("settled high", o_filt, 1'b1);

    pulseLow(2);
    pulseLow(3);

    // Square wave, 10 low / 10 high; O_FILT after edge k equals IO seen before edge k-4.
    for (int k = 0; k <= 70; k++) hist[k] = 1'b1;
    prev_filt = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      ext_val = (((k - 1) / 10) % 2 == 1) ? 1'b1 : 1'b0;
      hist[k + 4] = ext_val;
      tick();
      exp_filt = hist[k];
      checkOutput($sformatf("square filt k=%0d", k), o_filt, exp_filt);
      checkOutput($sformatf("square rise k=%0d", k), rise, exp_filt & ~prev_filt);
      checkOutput($sformatf("square fall k=%0d", k), fall, ~exp_filt & prev_filt);
      checkOutput($sformatf("square overlap k=%0d", k), rise & fall, 1'b0);
      prev_filt = exp_filt;
    end
    repeat (6) tick();

    // Reset while the filter counter is at 2 of 3 drops the pending update.
    ext_val = 1'b0;
    repeat (4) tick();
    checkOutput("mid pre-reset filt", o_filt, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid reset sync", o_sync, 1'b1);
    checkOutput("mid reset filt", o_filt, 1'b1);
    checkOutput("mid reset fall", fall, 1'b0);
    tick();
    checkOutput("mid held fall", fall, 1'b0);
    rst = 1'b0;
    checkFallAfterRelease("mid release");

    // Second instance: 4 sync stages, single-register filter, idle low.
    rst = 1'b1;
    #2;
    checkOutput("p2 rst sync", o_sync2, 1'b0);
    checkOutput("p2 rst filt", o_filt2, 1'b0);
    checkOutput("p2 rst rise", rise2, 1'b0);
    tick();
    rst = 1'b0;
    ext2_val = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("p2 sync k=%0d", k), o_sync2, (k >= 4) ? 1'b1 : 1'b0);
      checkOutput($sformatf("p2 filt k=%0d", k), o_filt2, (k >= 5) ? 1'b1 : 1'b0);
      checkOutput($sformatf("p2 rise k=%0d", k), rise2, (k == 5) ? 1'b1 : 1'b0);
      checkOutput($sformatf("p2 fall k=%0d", k), fall2, 1'b0);
    end
    checkOutput("p2 O", o2, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
